elevator_look_ctrl: RTL and testbench

Parametrised single-car elevator controller using the LOOK scheduling policy. It supports N floors, separate hall-up, hall-down and car-call request vectors, a door-dwell timer with a hold input, and per-floor request lamps. It sits between the button/sensor front-end and the motor/door drivers, replacing the fixed 5-floor controller. All outputs are registered, on posedge clk.

---
 rtl/elev_pkg.sv | 14 +
 rtl/elev_req_scan.sv | 42 ++++
 rtl/elevator_look_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_elevator_look_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/elev_pkg.sv
// Shared types and constants for the LOOK elevator controller.
package elev_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DN   = 2'd2,
        DOOR_OPEN = 2'd3
    } state_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/elev_req_scan.sv
// Combinational request scanner: summarises pending requests relative to a floor.
// Kept free of controller state so a multi-car dispatcher can reuse it.
module elev_req_scan
    import elev_pkg::*;
#(
    parameter int NUM_FLOORS = 8,
    parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
    input  logic [NUM_FLOORS-1:0] lamp_up,
    input  logic [NUM_FLOORS-1:0] lamp_dn,
    input  logic [NUM_FLOORS-1:0] lamp_car,
    input  logic [FLOOR_W-1:0]    floor_cur,
    output logic                  any_above,
    output logic                  any_below,
    output logic                  here_up,
    output logic                  here_dn,
    output logic                  here_car
);

    // Classify each floor as above, below or at floor_cur and OR its requests in.
    always_comb begin
        any_above = 1'b0;
        any_below = 1'b0;
        here_up   = 1'b0;
        here_dn   = 1'b0;
        here_car  = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i > int'(floor_cur)) begin
                any_above = any_above | lamp_up[i] | lamp_dn[i] | lamp_car[i];
            end
            if (i < int'(floor_cur)) begin
                any_below = any_below | lamp_up[i] | lamp_dn[i] | lamp_car[i];
            end
            if (i == int'(floor_cur)) begin
                here_up  = here_up  | lamp_up[i];
                here_dn  = here_dn  | lamp_dn[i];
                here_car = here_car | lamp_car[i];
            end
        end
    end

endmodule

// File: rtl/elevator_look_ctrl.sv
// Single-car elevator controller using LOOK scheduling with door dwell timer.
// Decisions look at latched lamps OR'd with this cycle's presses so a new
// button is acted on immediately; all outputs come straight from flops.
module elevator_look_ctrl
    import elev_pkg::*;
#(
    parameter int NUM_FLOORS  = 8,
    parameter int FLOOR_W     = $clog2(NUM_FLOORS),
    parameter int DOOR_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] hall_up,
    input  logic [NUM_FLOORS-1:0] hall_dn,
    input  logic [NUM_FLOORS-1:0] car_req,
    input  logic [FLOOR_W-1:0]    floor_cur,
    input  logic                  floor_valid,
    input  logic                  door_hold,
    output logic                  motor,
    output logic                  direction,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] lamp_up,
    output logic [NUM_FLOORS-1:0] lamp_dn,
    output logic [NUM_FLOORS-1:0] lamp_car,
    output logic                  serviced
);

    localparam int              CNT_W    = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DOOR_CYCLES - 1);

    state_t              state, state_nxt;
    logic                dir_nxt;
    logic [CNT_W-1:0]    door_cnt, cnt_nxt;

    logic [NUM_FLOORS-1:0] up_in, dn_in;
    logic [NUM_FLOORS-1:0] req_up, req_dn, req_car;
    logic [NUM_FLOORS-1:0] floor_hot;
    logic [NUM_FLOORS-1:0] clr_up, clr_dn, clr_car;
    logic                  pos_ok, at_top, at_bot, press_here;
    logic                  any_above, any_below, scan_up, scan_dn, scan_car;
    logic                  here_up, here_dn, here_car, here_any;
    logic                  clr_active, keep_up, keep_dn;

    // The top floor has no up button and the ground floor no down button.
    assign up_in   = hall_up & {1'b0, {(NUM_FLOORS-1){1'b1}}};
    assign dn_in   = hall_dn & {{(NUM_FLOORS-1){1'b1}}, 1'b0};
    assign req_up  = lamp_up  | up_in;
    assign req_dn  = lamp_dn  | dn_in;
    assign req_car = lamp_car | car_req;

    elev_req_scan #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_scan (
        .lamp_up   (req_up),
        .lamp_dn   (req_dn),
        .lamp_car  (req_car),
        .floor_cur (floor_cur),
        .any_above (any_above),
        .any_below (any_below),
        .here_up   (scan_up),
        .here_dn   (scan_dn),
        .here_car  (scan_car)
    );

    // Position qualifiers: a floor index outside the building counts as not level.
    always_comb begin
        pos_ok     = floor_valid && (int'(floor_cur) < NUM_FLOORS);
        at_top     = int'(floor_cur) == NUM_FLOORS - 1;
        at_bot     = floor_cur == '0;
        floor_hot  = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            floor_hot[i] = pos_ok && (int'(floor_cur) == i);
        end
        here_up    = pos_ok && scan_up;
        here_dn    = pos_ok && scan_dn;
        here_car   = pos_ok && scan_car;
        here_any   = here_up || here_dn || here_car;
        press_here = |(floor_hot & (up_in | dn_in | car_req));
    end

    // Next-state, direction and door-counter logic for the LOOK sweep.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = door_cnt;
        unique case (state)
            IDLE: begin
                if (pos_ok) begin
                    if (here_any) begin
                        state_nxt = DOOR_OPEN;
                    end else if (any_above && (direction == DIR_UP || !any_below)) begin
                        state_nxt = MOVE_UP;
                    end else if (any_below) begin
                        state_nxt = MOVE_DN;
                    end
                end
            end
            MOVE_UP: begin
                if (pos_ok && (here_car || here_up || (here_dn && !any_above) || at_top)) begin
                    state_nxt = DOOR_OPEN;
                end
            end
            MOVE_DN: begin
                if (pos_ok && (here_car || here_dn || (here_up && !any_below) || at_bot)) begin
                    state_nxt = DOOR_OPEN;
                end
            end
            DOOR_OPEN: begin
                if (door_hold || press_here) begin
                    cnt_nxt = CNT_LOAD;
                end else if (door_cnt == '0) begin
                    if (direction == DIR_UP && any_above) begin
                        state_nxt = MOVE_UP;
                    end else if (direction == DIR_DN && any_below) begin
                        state_nxt = MOVE_DN;
                    end else if (any_above) begin
                        state_nxt = MOVE_UP;
                    end else if (any_below) begin
                        state_nxt = MOVE_DN;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = door_cnt - CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (state != DOOR_OPEN && state_nxt == DOOR_OPEN) begin
            cnt_nxt = CNT_LOAD;
        end

        dir_nxt = direction;
        if (state_nxt == MOVE_UP) begin
            dir_nxt = DIR_UP;
        end else if (state_nxt == MOVE_DN) begin
            dir_nxt = DIR_DN;
        end
    end

    // Lamp clears at the served floor; the opposite hall lamp survives only while work remains ahead.
    always_comb begin
        clr_active = pos_ok && (state_nxt == DOOR_OPEN);
        keep_up    = (direction == DIR_DN) && any_below;
        keep_dn    = (direction == DIR_UP) && any_above;
        clr_car    = clr_active ? floor_hot : '0;
        clr_up     = (clr_active && !keep_up) ? floor_hot : '0;
        clr_dn     = (clr_active && !keep_dn) ? floor_hot : '0;
    end

    // Controller state and registered motor/door outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            door_cnt  <= '0;
            direction <= DIR_UP;
            motor     <= 1'b0;
            door_open <= 1'b0;
            serviced  <= 1'b0;
        end else begin
            state     <= state_nxt;
            door_cnt  <= cnt_nxt;
            direction <= dir_nxt;
            motor     <= (state_nxt == MOVE_UP) || (state_nxt == MOVE_DN);
            door_open <= state_nxt == DOOR_OPEN;
            serviced  <= (state != DOOR_OPEN) && (state_nxt == DOOR_OPEN);
        end
    end

    // Request lamps: presses set, service at the open door clears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lamp_up  <= '0;
            lamp_dn  <= '0;
            lamp_car <= '0;
        end else begin
            lamp_up  <= req_up  & ~clr_up;
            lamp_dn  <= req_dn  & ~clr_dn;
            lamp_car <= req_car & ~clr_car;
        end
    end

endmodule

// File: tb/tb_elevator_look_ctrl.sv
// Directed bench for elevator_look_ctrl: cycle-by-cycle vector table plus
// hand-written sequences for reset, door hold and re-press at an open door.
module tb_elevator_look_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] hall_up, hall_dn, car_req;
    logic [2:0] floor_cur;
    logic       floor_valid, door_hold;
    logic       motor, direction, door_open, serviced;
    logic [7:0] lamp_up, lamp_dn, lamp_car;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       do_rst;
        logic [7:0] up, dn, car;
        logic [2:0] fc;
        logic       fv, hold;
        logic       m, d, dr, s;
        logic [7:0] lu, ld, lc;
    } vec_t;

    vec_t vecs[$];

    elevator_look_ctrl #(
        .NUM_FLOORS  (8),
        .FLOOR_W     (3),
        .DOOR_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .hall_up     (hall_up),
        .hall_dn     (hall_dn),
        .car_req     (car_req),
        .floor_cur   (floor_cur),
        .floor_valid (floor_valid),
        .door_hold   (door_hold),
        .motor       (motor),
        .direction   (direction),
        .door_open   (door_open),
        .lamp_up     (lamp_up),
        .lamp_dn     (lamp_dn),
        .lamp_car    (lamp_car),
        .serviced    (serviced)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    function automatic vec_t mk(input logic r, input logic [7:0] up, input logic [7:0] dn,
                                input logic [7:0] car, input logic [2:0] fc, input logic fv,
                                input logic hold, input logic m, input logic d, input logic dr,
                                input logic s, input logic [7:0] lu, input logic [7:0] ld,
                                input logic [7:0] lc);
        vec_t v;
        v.do_rst = r; v.up = up; v.dn = dn; v.car = car; v.fc = fc; v.fv = fv; v.hold = hold;
        v.m = m; v.d = d; v.dr = dr; v.s = s; v.lu = lu; v.ld = ld; v.lc = lc;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic pulseReset(input logic [2:0] fc);
        @(negedge clk);
        rst         = 1'b1;
        hall_up     = '0;
        hall_dn     = '0;
        car_req     = '0;
        door_hold   = 1'b0;
        floor_cur   = fc;
        floor_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        if (v.do_rst) pulseReset(v.fc);
        @(negedge clk);
        hall_up     = v.up;
        hall_dn     = v.dn;
        car_req     = v.car;
        floor_cur   = v.fc;
        floor_valid = v.fv;
        door_hold   = v.hold;
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        @(negedge clk);
        hall_up   = '0;
        hall_dn   = '0;
        car_req   = '0;
        door_hold = 1'b0;
    endtask

    // Counts cycles the door remains open from now, bounded.
    task automatic countDoorOpen(output int n, output logic motor_seen);
        n = 0;
        motor_seen = 1'b0;
        while (door_open && n < 20) begin
            n++;
            motor_seen = motor_seen | motor;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int   n;
        logic ms;
        logic [27:0] got, exp;

        rst = 1'b0; hall_up = '0; hall_dn = '0; car_req = '0;
        floor_cur = '0; floor_valid = 1'b1; door_hold = 1'b0;

        // Scenario A: idle at 0, car call to 5, 4-cycle dwell.
        vecs.push_back(mk(1, 8'h00, 8'h00, 8'h00, 3'd0, 1, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mk(0, 8'h00, 8'h00, 8'h20, 3'd0, 1, 0, 1, 1, 0, 0, 8'h00, 8'h00, 8'h20));
        vecs.push_back(mk(0, 8'h00, 8'h00, 8'h00, 3'd1, 1, 0, 1, 1, 0, 0, 8'h00, 8'h00, 8'h20));
        vecs.push_back(mk(0, 8'h00, 8'h00, 8'h00, 3'd2, 0, 0, 1, 1, 0, 0, 8'h00, 8'h00, 8'h20));
        vecs.push_back(mk(0, 8'h00, 8'h00, 8'h00, 3'd3, 1, 0, 1, 1, 0, 0, 8'h00, 8'h00, 8'h20));
        vecs.push_back(mk(0, 8'h00, 8'h00, 8'h00, 3'd4, 1, 0, 1, 1, 0, 0, 8'h00, 8'h00, 8'h20));
        vecs.push_back(mk(0, 8'h00, 8'h00, 8'h00, 3'd5, 1, 0, 0, 1, 1, 1, 8'h00, 8'h00, 8'h00));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 8'h00, 8'h00, 8'h00, 3'd5, 1, 0, 0, 1, 1, 0, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mk(0, 8'h00, 8'h00, 8'h00, 3'd5, 1, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00));

        // Scenario B: from 1 with car 6 and hall-down 3; pass 3, stop 6, reverse, stop 3.
        vecs.push_back(mk(1, 8'h00, 8'h08, 8'h40, 3'd1, 1, 0, 1, 1, 0, 0, 8'h00, 8'h08, 8'h40));
        for (int f = 2; f <= 5; f++)
            vecs.push_back(mk(0, 8'h00, 8'h00, 8'h00, 3'(f), 1, 0, 1, 1, 0, 0, 8'h00, 8'h08, 8'h40));
        vecs.push_back(mk(0, 8'h00, 8'h00, 8'h00, 3'd6, 1, 0, 0, 1, 1, 1, 8'h00, 8'h08, 8'h00));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 8'h00, 8'h00, 8'h00, 3'd6, 1, 0, 0, 1, 1, 0, 8'h00, 8'h08, 8'h00));
        vecs.push_back(mk(0, 8'h00, 8'h00, 8'h00, 3'd6, 1, 0, 1, 0, 0, 0, 8'h00, 8'h08, 8'h00));
        vecs.push_back(mk(0, 8'h00, 8'h00, 8'h00, 3'd5, 1, 0, 1, 0, 0, 0, 8'h00, 8'h08, 8'h00));
        vecs.push_back(mk(0, 8'h00, 8'h00, 8'h00, 3'd4, 1, 0, 1, 0, 0, 0, 8'h00, 8'h08, 8'h00));
        vecs.push_back(mk(0, 8'h00, 8'h00, 8'h00, 3'd3, 1, 0, 0, 0, 1, 1, 8'h00, 8'h00, 8'h00));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 8'h00, 8'h00, 8'h00, 3'd3, 1, 0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mk(0, 8'h00, 8'h00, 8'h00, 3'd3, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00));

        // Scenario C: heading to 7, hall-up 4 pressed at 2 -> intermediate stop, then continue.
        vecs.push_back(mk(1, 8'h00, 8'h00, 8'h80, 3'd1, 1, 0, 1, 1, 0, 0, 8'h00, 8'h00, 8'h80));
        vecs.push_back(mk(0, 8'h10, 8'h00, 8'h00, 3'd2, 1, 0, 1, 1, 0, 0, 8'h10, 8'h00, 8'h80));
        vecs.push_back(mk(0, 8'h00, 8'h00, 8'h00, 3'd3, 1, 0, 1, 1, 0, 0, 8'h10, 8'h00, 8'h80));
        vecs.push_back(mk(0, 8'h00, 8'h00, 8'h00, 3'd4, 1, 0, 0, 1, 1, 1, 8'h00, 8'h00, 8'h80));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 8'h00, 8'h00, 8'h00, 3'd4, 1, 0, 0, 1, 1, 0, 8'h00, 8'h00, 8'h80));
        vecs.push_back(mk(0, 8'h00, 8'h00, 8'h00, 3'd4, 1, 0, 1, 1, 0, 0, 8'h00, 8'h00, 8'h80));
        vecs.push_back(mk(0, 8'h00, 8'h00, 8'h00, 3'd5, 1, 0, 1, 1, 0, 0, 8'h00, 8'h00, 8'h80));
        vecs.push_back(mk(0, 8'h00, 8'h00, 8'h00, 3'd6, 1, 0, 1, 1, 0, 0, 8'h00, 8'h00, 8'h80));
        vecs.push_back(mk(0, 8'h00, 8'h00, 8'h00, 3'd7, 1, 0, 0, 1, 1, 1, 8'h00, 8'h00, 8'h00));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 8'h00, 8'h00, 8'h00, 3'd7, 1, 0, 0, 1, 1, 0, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mk(0, 8'h00, 8'h00, 8'h00, 3'd7, 1, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            got = {motor, direction, door_open, serviced, lamp_up, lamp_dn, lamp_car};
            exp = {vecs[i].m, vecs[i].d, vecs[i].dr, vecs[i].s, vecs[i].lu, vecs[i].ld, vecs[i].lc};
            checkOutput($sformatf("vec%0d", i), 32'(got), 32'(exp));
        end

        // Asynchronous reset while moving up from floor 3.
        pulseReset(3'd3);
        @(negedge clk);
        car_req = 8'h80;
        @(posedge clk); #1;
        checkOutput("rst_pre_motor", 32'(motor), 32'd1);
        @(negedge clk);
        car_req = 8'h00;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_async_outs", 32'({motor, door_open, serviced}), 32'd0);
        checkOutput("rst_async_lamps", 32'({lamp_up, lamp_dn, lamp_car}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("rst_idle_after", 32'({motor, direction, door_open}), 32'b010);

        // Door hold at floor 2 for 6 cycles.
        pulseReset(3'd2);
        @(negedge clk);
        car_req = 8'h04;
        @(posedge clk); #1;
        checkOutput("hold_open", 32'({motor, door_open, serviced, lamp_car}), 32'({3'b011, 8'h00}));
        @(negedge clk);
        car_req   = 8'h00;
        door_hold = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("hold_cyc%0d", i), 32'({motor, door_open}), 32'b01);
        end
        @(negedge clk);
        door_hold = 1'b0;
        countDoorOpen(n, ms);
        checkOutput("hold_release_len", 32'(n), 32'd4);
        checkOutput("hold_no_motor", 32'(ms), 32'd0);

        // Hall-down pressed at floor 7 while the door is open.
        pulseReset(3'd6);
        @(negedge clk);
        car_req = 8'h80;
        @(posedge clk); #1;
        checkOutput("top_depart", 32'({motor, direction}), 32'b11);
        @(negedge clk);
        car_req   = 8'h00;
        floor_cur = 3'd7;
        @(posedge clk); #1;
        checkOutput("top_arrive", 32'({motor, door_open, serviced}), 32'b011);
        @(posedge clk); #1;
        checkOutput("top_svc_pulse", 32'(serviced), 32'd0);
        @(negedge clk);
        hall_dn = 8'h80;
        @(posedge clk); #1;
        checkOutput("top_repress_lamp", 32'({door_open, lamp_dn}), 32'({1'b1, 8'h00}));
        clearInputs();
        countDoorOpen(n, ms);
        checkOutput("top_reload_len", 32'(n), 32'd4);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("top_idle", 32'({motor, door_open, lamp_up, lamp_dn, lamp_car}), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
